adder_rs: RTL and testbench

Reservation station with an embedded integer adder/subtracter for one adder functional unit. It accepts an instruction issued by the reorder buffer on the instruction CDB when `CDB_inst_fu` equals `FU_ID`, and reads operand values and tags from the register file/status. Pending operands are captured by snooping the data CDB. The block computes ADD/SUB/ADDI/SUBI and broadcasts the result for one cycle on its data-CDB lane, indexed by the instruction's reorder-buffer slot. It sits between the reorder buffer's issue stage and the data CDB merge.

---
 rtl/adder_rs_if.sv | 39 +++
 rtl/adder_rs.sv | 258 +++++++++++++++++++++++++
 tb/tb_adder_rs.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_rs_if.sv
// adder_rs_if: issue bus, register-file read, data-CDB snoop and result
// broadcast signals of one adder reservation station, grouped as one bundle.
// The master side is the surrounding pipeline (ROB, register file, CDB);
// the slave side is the reservation station itself.
interface adder_rs_if #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 4,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 4
);
    logic [FU_INDEX-1:0]          CDB_inst_fu;
    logic [WORD_SIZE-1:0]         CDB_inst_inst;
    logic [RB_INDEX-1:0]          CDB_inst_RBindex;
    logic [REG_INDEX-1:0]         numj;
    logic [REG_INDEX-1:0]         numk;
    logic [WORD_SIZE-1:0]         vj;
    logic [WORD_SIZE-1:0]         vk;
    logic [RB_INDEX-1:0]          qj;
    logic [RB_INDEX-1:0]          qk;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic                         busy;
    logic                         res_valid;
    logic [RB_INDEX-1:0]          res_index;
    logic [WORD_SIZE-1:0]         res_data;

    modport master (
        output CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
        output vj, vk, qj, qk, CDB_data_data, CDB_data_valid,
        input  numj, numk, busy, res_valid, res_index, res_data
    );

    modport slave (
        input  CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
        input  vj, vk, qj, qk, CDB_data_data, CDB_data_valid,
        output numj, numk, busy, res_valid, res_index, res_data
    );
endinterface

// File: rtl/adder_rs.sv
// adder_rs: single-entry reservation station with an integer add/subtract
// unit. Accepts an issued instruction, waits for pending operands by
// snooping the data CDB, executes for ADD_LAT cycles and broadcasts the
// result for one cycle tagged with its ROB slot.
// Optional feature: define ADDER_SAT_EN to make add/subtract saturate to
// the signed range instead of wrapping modulo 2^WORD_SIZE.
module adder_rs #(
    parameter int       WORD_SIZE = 32,
    parameter int       RB_SIZE   = 8,
    parameter int       RB_INDEX  = 4,
    parameter int       READY     = 15,
    parameter int       REG_INDEX = 5,
    parameter int       FU_INDEX  = 4,
    parameter int       FU_ID     = 0,
    parameter int       ADD_LAT   = 1,
    parameter logic [3:0] OP_ADD  = 4'd0,
    parameter logic [3:0] OP_SUB  = 4'd1,
    parameter logic [3:0] OP_ADDI = 4'd5,
    parameter logic [3:0] OP_SUBI = 4'd6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    adder_rs_if.slave   bus
);
    localparam logic [RB_INDEX-1:0] TAG_READY = RB_INDEX'(READY);
    localparam logic [FU_INDEX-1:0] MY_FU     = FU_INDEX'(FU_ID);
    localparam logic [3:0]          CNT_INIT  = 4'(ADD_LAT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, EXEC = 2'd2, DONE = 2'd3} state_t;

    state_t               state_r;
    logic [3:0]           cnt_r;
    logic                 sub_r;
    logic [RB_INDEX-1:0]  rb_r;
    logic [RB_INDEX-1:0]  qj_r;
    logic [RB_INDEX-1:0]  qk_r;
    logic [WORD_SIZE-1:0] vj_r;
    logic [WORD_SIZE-1:0] vk_r;
    logic                 busy_r;
    logic                 res_valid_r;
    logic [RB_INDEX-1:0]  res_index_r;
    logic [WORD_SIZE-1:0] res_data_r;

    logic                 issue_s;
    logic                 dec_sub_s;
    logic                 dec_imm_s;
    logic [WORD_SIZE-1:0] imm_s;
    logic [RB_INDEX-1:0]  j_tag_s;
    logic [RB_INDEX-1:0]  k_tag_s;
    logic [WORD_SIZE-1:0] j_val_s;
    logic [WORD_SIZE-1:0] k_val_s;
    logic [RB_INDEX-1:0]  nj_tag_s;
    logic [RB_INDEX-1:0]  nk_tag_s;
    logic [WORD_SIZE-1:0] nj_val_s;
    logic [WORD_SIZE-1:0] nk_val_s;
    logic                 both_rdy_s;

    // True when the data-CDB lane addressed by a tag carries a valid result.
    // Tags beyond the lane count (including READY) never match a lane.
    function automatic logic lane_valid(input logic [RB_INDEX-1:0] tag,
                                        input logic [RB_SIZE-1:0] valid);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < RB_SIZE; i++) begin
            if (tag == RB_INDEX'(i)) begin
                hit = valid[i];
            end
        end
        return hit;
    endfunction

    // Value carried on the data-CDB lane addressed by a tag.
    function automatic logic [WORD_SIZE-1:0] lane_data(input logic [RB_INDEX-1:0] tag,
                                                       input logic [RB_SIZE*WORD_SIZE-1:0] data);
        logic [WORD_SIZE-1:0] d;
        d = {WORD_SIZE{1'b0}};
        for (int i = 0; i < RB_SIZE; i++) begin
            if (tag == RB_INDEX'(i)) begin
                d = data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
        return d;
    endfunction

    // Adder/subtracter: wraps by default, clamps to the signed range when
    // saturation is compiled in.
    function automatic logic [WORD_SIZE-1:0] alu_calc(input logic [WORD_SIZE-1:0] a,
                                                      input logic [WORD_SIZE-1:0] b,
                                                      input logic sub);
        logic [WORD_SIZE-1:0] r;
`ifdef ADDER_SAT_EN
        logic [WORD_SIZE:0] ext;
        if (sub) begin
            ext = {a[WORD_SIZE-1], a} - {b[WORD_SIZE-1], b};
        end else begin
            ext = {a[WORD_SIZE-1], a} + {b[WORD_SIZE-1], b};
        end
        if (ext[WORD_SIZE] != ext[WORD_SIZE-1]) begin
            r = ext[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
        end else begin
            r = ext[WORD_SIZE-1:0];
        end
`else
        if (sub) begin
            r = a - b;
        end else begin
            r = a + b;
        end
`endif
        return r;
    endfunction

    assign issue_s = (bus.CDB_inst_fu == MY_FU);
    assign imm_s   = {{(WORD_SIZE-13){1'b0}}, bus.CDB_inst_inst[12:0]};

    // Opcode decode of the instruction on the issue bus; unknown opcodes add.
    always_comb begin
        dec_sub_s = 1'b0;
        dec_imm_s = 1'b0;
        case (bus.CDB_inst_inst[31:28])
            OP_ADD:  begin dec_sub_s = 1'b0; dec_imm_s = 1'b0; end
            OP_SUB:  begin dec_sub_s = 1'b1; dec_imm_s = 1'b0; end
            OP_ADDI: begin dec_sub_s = 1'b0; dec_imm_s = 1'b1; end
            OP_SUBI: begin dec_sub_s = 1'b1; dec_imm_s = 1'b1; end
            default: begin dec_sub_s = 1'b0; dec_imm_s = 1'b0; end
        endcase
    end

    // Operand resolution: pick the issue-bus or held operands, then fill any
    // still-pending one from a valid CDB lane seen this cycle.
    always_comb begin
        j_tag_s = qj_r;
        j_val_s = vj_r;
        k_tag_s = qk_r;
        k_val_s = vk_r;
        if (state_r == IDLE) begin
            j_tag_s = bus.qj;
            j_val_s = bus.vj;
            if (dec_imm_s) begin
                k_tag_s = TAG_READY;
                k_val_s = imm_s;
            end else begin
                k_tag_s = bus.qk;
                k_val_s = bus.vk;
            end
        end else begin
            j_tag_s = qj_r;
            j_val_s = vj_r;
            k_tag_s = qk_r;
            k_val_s = vk_r;
        end

        if (j_tag_s == TAG_READY) begin
            nj_tag_s = TAG_READY;
            nj_val_s = j_val_s;
        end else if (lane_valid(j_tag_s, bus.CDB_data_valid)) begin
            nj_tag_s = TAG_READY;
            nj_val_s = lane_data(j_tag_s, bus.CDB_data_data);
        end else begin
            nj_tag_s = j_tag_s;
            nj_val_s = j_val_s;
        end

        if (k_tag_s == TAG_READY) begin
            nk_tag_s = TAG_READY;
            nk_val_s = k_val_s;
        end else if (lane_valid(k_tag_s, bus.CDB_data_valid)) begin
            nk_tag_s = TAG_READY;
            nk_val_s = lane_data(k_tag_s, bus.CDB_data_data);
        end else begin
            nk_tag_s = k_tag_s;
            nk_val_s = k_val_s;
        end

        both_rdy_s = (nj_tag_s == TAG_READY) && (nk_tag_s == TAG_READY);
    end

    // Station FSM: issue capture, operand wait, execute countdown, broadcast.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            sub_r       <= 1'b0;
            rb_r        <= {RB_INDEX{1'b0}};
            qj_r        <= TAG_READY;
            qk_r        <= TAG_READY;
            vj_r        <= {WORD_SIZE{1'b0}};
            vk_r        <= {WORD_SIZE{1'b0}};
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_index_r <= {RB_INDEX{1'b0}};
            res_data_r  <= {WORD_SIZE{1'b0}};
        end else if (flush) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    res_valid_r <= 1'b0;
                    if (issue_s) begin
                        sub_r  <= dec_sub_s;
                        rb_r   <= bus.CDB_inst_RBindex;
                        qj_r   <= nj_tag_s;
                        vj_r   <= nj_val_s;
                        qk_r   <= nk_tag_s;
                        vk_r   <= nk_val_s;
                        busy_r <= 1'b1;
                        cnt_r  <= CNT_INIT;
                        state_r <= both_rdy_s ? EXEC : WAIT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WAIT: begin
                    qj_r  <= nj_tag_s;
                    vj_r  <= nj_val_s;
                    qk_r  <= nk_tag_s;
                    vk_r  <= nk_val_s;
                    cnt_r <= CNT_INIT;
                    if (both_rdy_s) begin
                        state_r <= EXEC;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        res_data_r  <= alu_calc(vj_r, vk_r, sub_r);
                        res_index_r <= rb_r;
                        res_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.numj      = bus.CDB_inst_inst[22:18];
    assign bus.numk      = bus.CDB_inst_inst[17:13];
    assign bus.busy      = busy_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_index = res_index_r;
    assign bus.res_data  = res_data_r;
endmodule

// File: tb/tb_adder_rs.sv
// tb_adder_rs: scoreboard bench for adder_rs. Stimulus pushes expected
// broadcasts (ROB slot, value, cycle) into a queue; an independent monitor
// pops and compares whenever res_valid is seen.
module tb_adder_rs;
    localparam int W   = 32;
    localparam int L   = 3;
    localparam logic [3:0] RDY = 4'd15;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    adder_rs_if #(.WORD_SIZE(W), .RB_SIZE(8), .RB_INDEX(4), .REG_INDEX(5), .FU_INDEX(4)) bus ();

    adder_rs #(.ADD_LAT(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected broadcasts.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: signed arithmetic on wide integers, low word kept
    // (or clamped when saturation is built in).
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] j,
                                          input logic [31:0] vk, input logic [12:0] imm);
        logic [31:0] k;
        longint sj, sk, r;
        k  = (op == 4'd5 || op == 4'd6) ? {19'd0, imm} : vk;
        sj = longint'($signed(j));
        sk = longint'($signed(k));
        r  = (op == 4'd1 || op == 4'd6) ? sj - sk : sj + sk;
`ifdef ADDER_SAT_EN
        if (r > 64'sd2147483647)  r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
        return r[31:0];
    endfunction

    // Monitor: every broadcast must match the oldest expectation and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && bus.res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result index=%0d data=%0h expected=none",
                         bus.res_index, bus.res_data);
            end else begin
                e = sb.pop_front();
                check("res_index", 32'(bus.res_index), 32'(e.idx));
                check("res_data", bus.res_data, e.data);
                check("res_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic idle_bus();
        bus.CDB_inst_fu      = 4'd1;
        bus.CDB_inst_inst    = 32'd0;
        bus.CDB_inst_RBindex = 4'd0;
        bus.vj               = 32'd0;
        bus.vk               = 32'd0;
        bus.qj               = RDY;
        bus.qk               = RDY;
        bus.CDB_data_data    = '0;
        bus.CDB_data_valid   = 8'd0;
    endtask

    task automatic push(input logic [3:0] idx, input logic [31:0] data, input int due);
        exp_t e;
        e.idx = idx; e.data = data; e.due = due;
        sb.push_back(e);
    endtask

    // Drives one issue (caller is away from the edge), returns the issue edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] rb, input logic [12:0] imm,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, output int e0);
        logic [4:0] rs, rt;
        rs = 5'($urandom);
        rt = 5'($urandom);
        bus.CDB_inst_fu      = 4'd0;
        bus.CDB_inst_inst    = {op, 5'($urandom), rs, rt, imm};
        bus.CDB_inst_RBindex = rb;
        bus.vj = vj; bus.vk = vk; bus.qj = qj; bus.qk = qk;
        #1;
        check("numj", 32'(bus.numj), 32'(rs));
        check("numk", 32'(bus.numk), 32'(rt));
        @(posedge clk);
        #1;
        e0 = cyc;
        idle_bus();
    endtask

    // Presents one CDB lane for a single edge, returns that edge.
    task automatic provide_lane(input int tag, input logic [31:0] data, output int ek);
        @(negedge clk);
        bus.CDB_data_valid[tag]          = 1'b1;
        bus.CDB_data_data[tag*W +: W]    = data;
        @(posedge clk);
        #1;
        ek = cyc;
        bus.CDB_data_valid = 8'd0;
        bus.CDB_data_data  = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) return;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic to_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Run-time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        int e0, ek, last;
        logic [3:0]  op, rb, tj, tk;
        logic [31:0] jv, kv, r;
        logic [12:0] imm;
        logic j_pend, k_pend, at_issue;
        logic [3:0] ops [5];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd5; ops[3] = 4'd6; ops[4] = 4'd3;

        reset_n = 1'b0;
        flush   = 1'b0;
        idle_bus();
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_index", 32'(bus.res_index), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ready operands: 5 + 7 to slot 3.
        @(negedge clk);
        issue(4'd0, 4'd3, 13'd0, 32'd5, 32'd7, RDY, RDY, e0);
        push(4'd3, model(4'd0, 32'd5, 32'd7, 13'd0), e0 + L);
        check("busy_after_issue", 32'(bus.busy), 32'd1);
        to_neg(e0 + L);
        check("busy_in_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("res_valid_after_done", 32'(bus.res_valid), 32'd0);

        // SUB with j pending on lane 2.
        @(negedge clk);
        issue(4'd1, 4'd5, 13'd0, 32'hDEADBEEF, 32'd1, 4'd2, RDY, e0);
        repeat (2) @(negedge clk);
        check("busy_waiting", 32'(bus.busy), 32'd1);
        provide_lane(2, 32'd10, ek);
        push(4'd5, model(4'd1, 32'd10, 32'd1, 13'd0), ek + L);
        wait_idle();

        // ADDI with max immediate; k tag pending must be ignored.
        @(negedge clk);
        issue(4'd5, 4'd1, 13'h1FFF, 32'd1, 32'hFFFF0000, RDY, 4'd6, e0);
        push(4'd1, model(4'd5, 32'd1, 32'd0, 13'h1FFF), e0 + L);
        wait_idle();

        // Overflow / underflow boundaries.
        @(negedge clk);
        issue(4'd0, 4'd2, 13'd0, 32'h7FFFFFFF, 32'd1, RDY, RDY, e0);
        push(4'd2, model(4'd0, 32'h7FFFFFFF, 32'd1, 13'd0), e0 + L);
        wait_idle();
        @(negedge clk);
        issue(4'd1, 4'd4, 13'd0, 32'd0, 32'd1, RDY, RDY, e0);
        push(4'd4, model(4'd1, 32'd0, 32'd1, 13'd0), e0 + L);
        wait_idle();

        // Flush while waiting on an operand; the late lane must not revive it.
        @(negedge clk);
        issue(4'd0, 4'd6, 13'd0, 32'd0, 32'd3, 4'd4, RDY, e0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("busy_after_flush_wait", 32'(bus.busy), 32'd0);
        provide_lane(4, 32'd99, ek);
        repeat (L + 2) @(negedge clk);
        check("busy_idle_after_lane", 32'(bus.busy), 32'd0);
        @(negedge clk);
        issue(4'd0, 4'd7, 13'd0, 32'd40, 32'd2, RDY, RDY, e0);
        push(4'd7, model(4'd0, 32'd40, 32'd2, 13'd0), e0 + L);
        wait_idle();

        // Flush on the edge that would enter DONE: no broadcast.
        @(negedge clk);
        issue(4'd0, 4'd2, 13'd0, 32'd8, 32'd8, RDY, RDY, e0);
        to_neg(e0 + L - 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("busy_after_flush_done", 32'(bus.busy), 32'd0);
        check("res_valid_after_flush", 32'(bus.res_valid), 32'd0);

        // Reset mid-EXEC: outputs clear at once, instruction lost.
        @(negedge clk);
        issue(4'd0, 4'd6, 13'd0, 32'd100, 32'd200, RDY, RDY, e0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_res_valid", 32'(bus.res_valid), 32'd0);
        check("arst_res_index", 32'(bus.res_index), 32'd0);
        check("arst_res_data", bus.res_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (L + 3) @(negedge clk);
        check("busy_after_arst", 32'(bus.busy), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            op  = ops[$urandom_range(0, 4)];
            rb  = 4'($urandom_range(0, 7));
            imm = 13'($urandom);
            jv  = $urandom;
            kv  = $urandom;
            tj  = 4'($urandom_range(0, 7));
            tk  = 4'((int'(tj) + $urandom_range(1, 7)) % 8);
            j_pend   = ($urandom_range(0, 2) == 0);
            k_pend   = ($urandom_range(0, 2) == 0);
            at_issue = ($urandom_range(0, 3) == 0);
            r = model(op, jv, kv, imm);
            @(negedge clk);
            if (j_pend && at_issue) begin
                bus.CDB_data_valid[tj]      = 1'b1;
                bus.CDB_data_data[tj*W +: W] = jv;
            end
            issue(op, rb, imm, j_pend ? 32'($urandom) : jv,
                  k_pend ? 32'($urandom) : kv,
                  j_pend ? tj : RDY, k_pend ? tk : RDY, e0);
            last = e0;
            if (j_pend && !at_issue) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                provide_lane(int'(tj), jv, last);
            end
            if (k_pend && !(op == 4'd5 || op == 4'd6)) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                provide_lane(int'(tk), kv, last);
            end
            push(rb, r, last + L);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
